// File: rtl/alu_pkg.sv
// Shared definitions for the sequential MULT/MULTU datapath.
// FSM state encoding and a sizing helper for the iteration counter.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Bits needed to hold the values 0..width inclusive.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/cla_adder_wbit.sv
// WIDTH-bit adder built from 4-bit carry-lookahead groups.
// Group carries ripple from one group to the next.
module cla_adder_wbit #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);

   localparam int NG = WIDTH / 4;

   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_p;
   logic [NG-1:0]    w_gg;
   logic [NG-1:0]    w_gp;
   logic [NG:0]      w_c;

   assign w_g = A & B;
   assign w_p = A ^ B;

   for (genvar k = 0; k < NG; k++) begin : g_grp
      logic [3:0] w_gl;
      logic [3:0] w_pl;
      logic       w_ci;
      logic       w_c1;
      logic       w_c2;
      logic       w_c3;

      assign w_gl = w_g[4*k +: 4];
      assign w_pl = w_p[4*k +: 4];
      assign w_ci = w_c[k];

      assign w_c1 = w_gl[0] | (w_pl[0] & w_ci);
      assign w_c2 = w_gl[1] | (w_pl[1] & w_gl[0]) | (w_pl[1] & w_pl[0] & w_ci);
      assign w_c3 = w_gl[2] | (w_pl[2] & w_gl[1]) | (w_pl[2] & w_pl[1] & w_gl[0])
                  | (w_pl[2] & w_pl[1] & w_pl[0] & w_ci);

      // Group generate/propagate let the inter-group carry skip the inner bits.
      assign w_gg[k] = w_gl[3] | (w_pl[3] & w_gl[2]) | (w_pl[3] & w_pl[2] & w_gl[1])
                     | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0]);
      assign w_gp[k] = &w_pl;

      assign Sum[4*k +: 4] = w_pl ^ {w_c3, w_c2, w_c1, w_ci};
   end

   always_comb begin
      logic c;
      w_c = '0;
      c   = Cin;
      for (int k = 0; k < NG; k++) begin
         w_c[k] = c;
         c      = w_gg[k] | (w_gp[k] & c);
      end
      w_c[NG] = c;
   end

   assign Cout = w_c[NG];

endmodule

// File: rtl/alu_seq_multiplier.sv
// Iterative shift-add multiplier for MULT/MULTU: one partial-product add per
// cycle, signed operands handled by magnitude multiply and a final sign fix.
module alu_seq_multiplier
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               Start,
   input  logic               Signed,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               Busy,
   output logic               Done,
   output logic [2*WIDTH-1:0] Product
);

   localparam int             CW       = cnt_w(WIDTH);
   localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   state_t               r_state;
   state_t               w_next;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic [CW-1:0]        r_cnt;
   logic                 r_neg;
   logic                 r_busy;
   logic                 r_done;
   logic [2*WIDTH-1:0]   r_product;

   logic [WIDTH-1:0]     w_pp_b;
   logic [WIDTH-1:0]     w_pp_sum;
   logic                 w_pp_co;
   logic [WIDTH-1:0]     w_nlo_a;
   logic [WIDTH-1:0]     w_nlo_sum;
   logic                 w_nlo_co;
   logic [WIDTH-1:0]     w_nhi_a;
   logic                 w_nhi_cin;
   logic [WIDTH-1:0]     w_nhi_sum;
   logic                 w_nhi_cout_unused;
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [2*WIDTH-1:0]   w_fix;

   // Partial-product adder: HI_acc + mcand when the current multiplier bit is set.
   assign w_pp_b = r_lo[0] ? r_mcand : '0;

   cla_adder_wbit #(.WIDTH(WIDTH)) u_pp_add (
      .A    (r_hi),
      .B    (w_pp_b),
      .Cin  (1'b0),
      .Sum  (w_pp_sum),
      .Cout (w_pp_co)
   );

   // Negation path: in IDLE the two adders negate A and B; in FIX they form
   // one 2W-bit negate of the accumulator with the low carry chained upward.
   assign w_nlo_a   = (r_state == FIX) ? ~r_lo    : ~A;
   assign w_nhi_a   = (r_state == FIX) ? ~r_hi    : ~B;
   assign w_nhi_cin = (r_state == FIX) ? w_nlo_co : 1'b1;

   cla_adder_wbit #(.WIDTH(WIDTH)) u_neg_lo (
      .A    (w_nlo_a),
      .B    ('0),
      .Cin  (1'b1),
      .Sum  (w_nlo_sum),
      .Cout (w_nlo_co)
   );

   cla_adder_wbit #(.WIDTH(WIDTH)) u_neg_hi (
      .A    (w_nhi_a),
      .B    ('0),
      .Cin  (w_nhi_cin),
      .Sum  (w_nhi_sum),
      .Cout (w_nhi_cout_unused)
   );

   assign w_mag_a = (Signed & A[WIDTH-1]) ? w_nlo_sum : A;
   assign w_mag_b = (Signed & B[WIDTH-1]) ? w_nhi_sum : B;
   assign w_fix   = r_neg ? {w_nhi_sum, w_nlo_sum} : {r_hi, r_lo};

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (Start) w_next = CALC;
         CALC:    if (r_cnt == CNT_ONE) w_next = FIX;
         FIX:     w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_mcand   <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
         r_product <= '0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == CALC) || (w_next == FIX);
         r_done  <= (w_next == DONE);
         case (r_state)
            IDLE: begin
               if (Start) begin
                  r_mcand <= w_mag_a;
                  r_lo    <= w_mag_b;
                  r_hi    <= '0;
                  r_neg   <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                  r_cnt   <= CNT_INIT;
               end
            end
            CALC: begin
               // {C, HI_acc, LO_acc} >> 1 after the conditional add.
               r_hi  <= {w_pp_co, w_pp_sum[WIDTH-1:1]};
               r_lo  <= {w_pp_sum[0], r_lo[WIDTH-1:1]};
               r_cnt <= r_cnt - CNT_ONE;
            end
            FIX: begin
               r_product <= w_fix;
            end
            default: begin
            end
         endcase
      end
   end

   assign Busy    = r_busy;
   assign Done    = r_done;
   assign Product = r_product;

endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Directed bench for alu_seq_multiplier at WIDTH=8 with hand-computed results.
module tb_alu_seq_multiplier;

   localparam int W = 8;

   logic           clk;
   logic           rst_n;
   logic           Start;
   logic           Signed;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic           Busy;
   logic           Done;
   logic [2*W-1:0] Product;

   int checks = 0;
   int errors = 0;
   int lat;
   int bcnt;
   int dcnt;

   alu_seq_multiplier #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .Start   (Start),
      .Signed  (Signed),
      .A       (A),
      .B       (B),
      .Busy    (Busy),
      .Done    (Done),
      .Product (Product)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      Signed = s;
      A      = a;
      B      = b;
      Start  = 1'b1;
      tick();
      Start  = 1'b0;
   endtask

   // Counts edges until Done is seen, plus Busy-high samples along the way.
   task automatic wait_done(output int n, output int busy_n);
      n      = 0;
      busy_n = Busy ? 1 : 0;
      while (!Done && n < 40) begin
         tick();
         n++;
         if (Busy) busy_n++;
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      Start  = 1'b0;
      Signed = 1'b0;
      A      = '0;
      B      = '0;
      #12;
      chk("reset_busy", 64'(Busy), 64'd0);
      chk("reset_done", 64'(Done), 64'd0);
      chk("reset_product", 64'(Product), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Unsigned max with latency and Busy width.
      start_op(1'b0, 8'hFF, 8'hFF);
      wait_done(lat, bcnt);
      chk("umax_latency", 64'(lat), 64'd9);
      chk("umax_busy_cycles", 64'(bcnt), 64'd9);
      chk("umax_product", 64'(Product), 64'hFE01);
      chk("umax_done_busy", 64'(Busy), 64'd0);
      tick();
      chk("umax_done_pulse", 64'(Done), 64'd0);

      // Signed mixed signs, both orders.
      start_op(1'b1, 8'hFD, 8'h05);
      wait_done(lat, bcnt);
      chk("smix_a_product", 64'(Product), 64'hFFF1);
      tick();
      start_op(1'b1, 8'h05, 8'hFD);
      wait_done(lat, bcnt);
      chk("smix_b_product", 64'(Product), 64'hFFF1);
      tick();

      // Signed corners.
      start_op(1'b1, 8'h80, 8'h80);
      wait_done(lat, bcnt);
      chk("scorner_mneg_sq", 64'(Product), 64'h4000);
      tick();
      start_op(1'b1, 8'h00, 8'h80);
      wait_done(lat, bcnt);
      chk("scorner_zero", 64'(Product), 64'h0000);
      tick();
      start_op(1'b1, 8'h80, 8'h01);
      wait_done(lat, bcnt);
      chk("scorner_mneg_one", 64'(Product), 64'hFF80);
      tick();

      // Back-to-back: Start during CALC and DONE is ignored, next IDLE accepted.
      start_op(1'b0, 8'd7, 8'd9);
      A     = 8'd1;
      B     = 8'd1;
      Start = 1'b1;
      tick();
      tick();
      Start = 1'b0;
      chk("b2b_busy_mid", 64'(Busy), 64'd1);
      chk("b2b_product_hold_mid", 64'(Product), 64'hFF80);
      lat = 2;
      while (!Done && lat < 40) begin
         tick();
         lat++;
      end
      chk("b2b_first_latency", 64'(lat), 64'd9);
      chk("b2b_first_product", 64'(Product), 64'h003F);
      Start = 1'b1;
      tick();
      chk("b2b_done_ignored_done", 64'(Done), 64'd0);
      chk("b2b_done_ignored_busy", 64'(Busy), 64'd0);
      tick();
      Start = 1'b0;
      chk("b2b_idle_accept_busy", 64'(Busy), 64'd1);
      chk("b2b_idle_accept_hold", 64'(Product), 64'h003F);
      dcnt = 0;
      wait_done(lat, bcnt);
      chk("b2b_second_latency", 64'(lat), 64'd9);
      chk("b2b_second_product", 64'(Product), 64'h0001);
      tick();

      // Asynchronous reset in the middle of an operation.
      start_op(1'b0, 8'hFF, 8'hFF);
      tick();
      tick();
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(Busy), 64'd0);
      chk("rst_mid_done", 64'(Done), 64'd0);
      chk("rst_mid_product", 64'(Product), 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst_release_busy", 64'(Busy), 64'd0);
      start_op(1'b0, 8'd3, 8'd4);
      wait_done(lat, bcnt);
      chk("post_rst_latency", 64'(lat), 64'd9);
      chk("post_rst_product", 64'(Product), 64'h000C);

      // Product holds while idle and operands toggle.
      for (int i = 0; i < 20; i++) begin
         A = W'($urandom);
         B = W'($urandom);
         Signed = 1'($urandom);
         tick();
         chk("hold_product", 64'(Product), 64'h000C);
         if (Done) dcnt++;
      end
      chk("hold_no_done", 64'(dcnt), 64'd0);
      chk("hold_not_busy", 64'(Busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
